// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, field widths and the
// fixed program that computes sum(1..N) mod 256.
package cpu_pkg;

  localparam int OP_W    = 4;
  localparam int IMM_W   = 8;
  localparam int INSTR_W = OP_W + IMM_W;
  localparam int PC_W    = 5;
  localparam int DATA_W  = 8;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OP_W-1:0] OP_STR  = 4'h4;
  localparam logic [OP_W-1:0] OP_LDR  = 4'h5;
  localparam logic [OP_W-1:0] OP_ADDR = 4'h6;
  localparam logic [OP_W-1:0] OP_SUBR = 4'h7;
  localparam logic [OP_W-1:0] OP_IN   = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT  = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OP_W-1:0] OP_JZ   = 4'hB;
  localparam logic [OP_W-1:0] OP_JNZ  = 4'hC;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // R0 holds the countdown N, R1 the running sum; unused addresses read as NOP.
  function automatic logic [INSTR_W-1:0] rom_word(input logic [PC_W-1:0] addr);
    case (addr)
      5'd0:    rom_word = {OP_IN,   8'd0};
      5'd1:    rom_word = {OP_STR,  8'd0};
      5'd2:    rom_word = {OP_LDI,  8'd0};
      5'd3:    rom_word = {OP_STR,  8'd1};
      5'd4:    rom_word = {OP_LDR,  8'd0};
      5'd5:    rom_word = {OP_JZ,   8'd12};
      5'd6:    rom_word = {OP_ADDR, 8'd1};
      5'd7:    rom_word = {OP_STR,  8'd1};
      5'd8:    rom_word = {OP_LDR,  8'd0};
      5'd9:    rom_word = {OP_SUBI, 8'd1};
      5'd10:   rom_word = {OP_STR,  8'd0};
      5'd11:   rom_word = {OP_JMP,  8'd4};
      5'd12:   rom_word = {OP_LDR,  8'd1};
      5'd13:   rom_word = {OP_OUT,  8'd0};
      5'd14:   rom_word = {OP_JMP,  8'd0};
      default: rom_word = {OP_NOP,  8'd0};
    endcase
  endfunction

endpackage

// File: rtl/cpu_if.sv
// Board-facing signals of the CPU: keypad/enter inputs and result/status outputs.
interface cpu_if;
  import cpu_pkg::*;

  logic              enter;
  logic              k1;
  logic              k2;
  logic [6:0]        entry_value;
  logic [DATA_W-1:0] out_value;
  logic              out_valid;
  logic              halted;

  modport master (
    output enter, k1, k2,
    input  entry_value, out_value, out_valid, halted
  );

  modport slave (
    input  enter, k1, k2,
    output entry_value, out_value, out_valid, halted
  );

endinterface

// File: rtl/cpu_key_input.sv
// Keypad front end: synchronizes and debounces k1/k2/enter, keeps the two
// decimal digits and captures the entered value into the CPU input register.
module cpu_key_input
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              k1,
  input  logic              k2,
  input  logic              enter,
  input  logic              in_consume,
  output logic [6:0]        entry_value,
  output logic [DATA_W-1:0] in_reg,
  output logic              in_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] IDLE_LEVELS = 3'b011;   // {enter, k2, k1}

  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       db_r;
  logic [CNT_W-1:0] cnt_r [3];
  logic [2:0]       accept_s;
  logic [1:0]       press_r;
  logic             enter_rise_r;
  logic [3:0]       tens_r;
  logic [3:0]       ones_r;
  logic [6:0]       entry_s;
  logic [6:0]       entry_value_r;
  logic [DATA_W-1:0] in_reg_r;
  logic             in_valid_r;

  // Two-flop synchronizer for all three raw inputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= IDLE_LEVELS;
      sync2_r <= IDLE_LEVELS;
    end else begin
      sync1_r <= {enter, k2, k1};
      sync2_r <= sync1_r;
    end
  end

  // A debouncer accepts on the Nth consecutive sample that differs from its level
  always_comb begin
    accept_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if ((sync2_r[i] != db_r[i]) && (cnt_r[i] == CNT_W'(DEBOUNCE_CYCLES - 1))) begin
        accept_s[i] = 1'b1;
      end else begin
        accept_s[i] = 1'b0;
      end
    end
  end

  // Debounce counters, accepted levels and one-cycle edge pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_r         <= IDLE_LEVELS;
      press_r      <= 2'b00;
      enter_rise_r <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      press_r      <= accept_s[1:0] & ~sync2_r[1:0];
      enter_rise_r <= accept_s[2] & sync2_r[2];
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (accept_s[i]) begin
          db_r[i]  <= sync2_r[i];
          cnt_r[i] <= {CNT_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  assign entry_s = ({3'b000, tens_r} * 7'd10) + {3'b000, ones_r};

  // Digit counters and input-register capture; a new capture beats a consume
  always_ff @(posedge clk) begin
    if (!rst) begin
      tens_r        <= 4'd0;
      ones_r        <= 4'd0;
      entry_value_r <= 7'd0;
      in_reg_r      <= {DATA_W{1'b0}};
      in_valid_r    <= 1'b0;
    end else begin
      if (press_r[0]) begin
        tens_r <= (tens_r == 4'd9) ? 4'd0 : tens_r + 4'd1;
      end
      if (press_r[1]) begin
        ones_r <= (ones_r == 4'd9) ? 4'd0 : ones_r + 4'd1;
      end
      entry_value_r <= entry_s;
      if (enter_rise_r) begin
        in_reg_r   <= {1'b0, entry_s};
        in_valid_r <= 1'b1;
      end else if (in_consume) begin
        in_valid_r <= 1'b0;
      end
    end
  end

  assign entry_value = entry_value_r;
  assign in_reg      = in_reg_r;
  assign in_valid    = in_valid_r;

endmodule

// File: rtl/cpu_top.sv
// 8-bit accumulator CPU with keypad front end; runs the built-in summation
// program and reports each result on out_value with a one-cycle out_valid.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLOCK_50,
  input  logic rst,
  cpu_if.slave io
);

  logic [PC_W-1:0]    pc_r;
  logic [DATA_W-1:0]  acc_r;
  logic [DATA_W-1:0]  regs_r [4];
  logic [DATA_W-1:0]  out_value_r;
  logic               out_valid_r;
  logic               halted_r;

  logic [INSTR_W-1:0] instr_s;
  logic [OP_W-1:0]    op_s;
  logic [IMM_W-1:0]   imm_s;
  logic [DATA_W-1:0]  reg_rd_s;
  logic [DATA_W-1:0]  in_reg_s;
  logic               in_valid_s;
  logic               in_consume_s;
  logic [6:0]         entry_value_s;

  cpu_key_input #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_input (
    .clk         (CLOCK_50),
    .rst         (rst),
    .k1          (io.k1),
    .k2          (io.k2),
    .enter       (io.enter),
    .in_consume  (in_consume_s),
    .entry_value (entry_value_s),
    .in_reg      (in_reg_s),
    .in_valid    (in_valid_s)
  );

  assign instr_s      = rom_word(pc_r);
  assign op_s         = instr_s[INSTR_W-1:IMM_W];
  assign imm_s        = instr_s[IMM_W-1:0];
  assign reg_rd_s     = regs_r[imm_s[1:0]];
  assign in_consume_s = (op_s == OP_IN) && in_valid_s && !halted_r;

  // Fetch/execute: one instruction per clock, PC frozen once halted
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      pc_r        <= {PC_W{1'b0}};
      acc_r       <= {DATA_W{1'b0}};
      out_value_r <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      out_valid_r <= 1'b0;
      if (!halted_r) begin
        pc_r <= pc_r + 5'd1;
        case (op_s)
          OP_LDI:  acc_r <= imm_s;
          OP_ADDI: acc_r <= acc_r + imm_s;
          OP_SUBI: acc_r <= acc_r - imm_s;
          OP_STR:  regs_r[imm_s[1:0]] <= acc_r;
          OP_LDR:  acc_r <= reg_rd_s;
          OP_ADDR: acc_r <= acc_r + reg_rd_s;
          OP_SUBR: acc_r <= acc_r - reg_rd_s;
          OP_IN: begin
            if (in_valid_s) begin
              acc_r <= in_reg_s;
            end else begin
              pc_r <= pc_r;
            end
          end
          OP_OUT: begin
            out_value_r <= acc_r;
            out_valid_r <= 1'b1;
          end
          OP_JMP:  pc_r <= imm_s[PC_W-1:0];
          OP_JZ: begin
            if (acc_r == 8'd0) begin
              pc_r <= imm_s[PC_W-1:0];
            end
          end
          OP_JNZ: begin
            if (acc_r != 8'd0) begin
              pc_r <= imm_s[PC_W-1:0];
            end
          end
          OP_HALT: begin
            halted_r <= 1'b1;
            pc_r     <= pc_r;
          end
          default: ;
        endcase
      end
    end
  end

  assign io.entry_value = entry_value_s;
  assign io.out_value   = out_value_r;
  assign io.out_valid   = out_valid_r;
  assign io.halted      = halted_r;

endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: keypad entry, summation results, reset and debounce behaviour.
module tb_cpu_top;

  logic clk;
  logic rst;
  int   cmp_count = 0;
  int   err_count = 0;
  int   pulse_total = 0;
  logic [7:0] last_out = 8'd0;

  cpu_if io ();
  cpu_if io2 ();

  cpu_top #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .io       (io)
  );

  cpu_top #(.DEBOUNCE_CYCLES(200)) dut2 (
    .CLOCK_50 (clk),
    .rst      (rst),
    .io       (io2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (io.out_valid === 1'b1) begin
      pulse_total <= pulse_total + 1;
      last_out    <= io.out_value;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_k(input int which);
    if (which == 1) io.k1 = 1'b0;
    else io.k2 = 1'b0;
    tick(12);
    io.k1 = 1'b1;
    io.k2 = 1'b1;
    tick(12);
  endtask

  task automatic pulse_enter();
    io.enter = 1'b1;
    tick(12);
    io.enter = 1'b0;
    tick(12);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    int start;
    rst = 1'b0;
    io.enter = 1'b0; io.k1 = 1'b1; io.k2 = 1'b1;
    io2.enter = 1'b0; io2.k1 = 1'b1; io2.k2 = 1'b1;
    tick(2);
    start = pulse_total;
    tick(200);
    cmp_count++; if (dut.pc_r !== 5'd0) begin err_count++; $display("FAIL reset_pc got=%0d exp=0", dut.pc_r); end
    cmp_count++; if (io.entry_value !== 7'd0) begin err_count++; $display("FAIL reset_entry got=%0d exp=0", io.entry_value); end
    cmp_count++; if (io.out_value !== 8'd0) begin err_count++; $display("FAIL reset_out_value got=%0d exp=0", io.out_value); end
    cmp_count++; if (io.out_valid !== 1'b0) begin err_count++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
    cmp_count++; if (io.halted !== 1'b0) begin err_count++; $display("FAIL reset_halted got=%b exp=0", io.halted); end
    cmp_count++; if (pulse_total - start !== 0) begin err_count++; $display("FAIL reset_pulses got=%0d exp=0", pulse_total - start); end
  endtask

  task automatic test_idle_stall();
    int start;
    start = pulse_total;
    rst = 1'b1;
    tick(50);
    cmp_count++; if (dut.pc_r !== 5'd0) begin err_count++; $display("FAIL stall_pc got=%0d exp=0", dut.pc_r); end
    cmp_count++; if (io.halted !== 1'b0) begin err_count++; $display("FAIL stall_halted got=%b exp=0", io.halted); end
    cmp_count++; if (pulse_total - start !== 0) begin err_count++; $display("FAIL stall_pulses got=%0d exp=0", pulse_total - start); end
  endtask

  task automatic test_sum4();
    int start;
    repeat (4) press_k(2);
    cmp_count++; if (io.entry_value !== 7'd4) begin err_count++; $display("FAIL sum4_entry got=%0d exp=4", io.entry_value); end
    start = pulse_total;
    pulse_enter();
    tick(200);
    cmp_count++; if (pulse_total - start !== 1) begin err_count++; $display("FAIL sum4_pulses got=%0d exp=1", pulse_total - start); end
    cmp_count++; if (last_out !== 8'd10) begin err_count++; $display("FAIL sum4_value got=%0d exp=10", last_out); end
    cmp_count++; if (dut.pc_r !== 5'd0) begin err_count++; $display("FAIL sum4_pc_back got=%0d exp=0", dut.pc_r); end
  endtask

  task automatic test_sum99_wrap();
    int start;
    do_reset();
    repeat (9) press_k(1);
    repeat (9) press_k(2);
    cmp_count++; if (io.entry_value !== 7'd99) begin err_count++; $display("FAIL sum99_entry got=%0d exp=99", io.entry_value); end
    start = pulse_total;
    pulse_enter();
    tick(1200);
    cmp_count++; if (pulse_total - start !== 1) begin err_count++; $display("FAIL sum99_pulses got=%0d exp=1", pulse_total - start); end
    cmp_count++; if (last_out !== 8'd86) begin err_count++; $display("FAIL sum99_value got=%0d exp=86", last_out); end
    press_k(1);
    cmp_count++; if (io.entry_value !== 7'd9) begin err_count++; $display("FAIL tens_wrap got=%0d exp=9", io.entry_value); end
    press_k(2);
    cmp_count++; if (io.entry_value !== 7'd0) begin err_count++; $display("FAIL ones_wrap got=%0d exp=0", io.entry_value); end
  endtask

  task automatic test_zero_and_ten();
    int start;
    start = pulse_total;
    pulse_enter();
    tick(100);
    cmp_count++; if (pulse_total - start !== 1) begin err_count++; $display("FAIL zero_pulses got=%0d exp=1", pulse_total - start); end
    cmp_count++; if (last_out !== 8'd0) begin err_count++; $display("FAIL zero_value got=%0d exp=0", last_out); end
    press_k(1);
    cmp_count++; if (io.entry_value !== 7'd10) begin err_count++; $display("FAIL ten_entry got=%0d exp=10", io.entry_value); end
    start = pulse_total;
    pulse_enter();
    tick(300);
    cmp_count++; if (pulse_total - start !== 1) begin err_count++; $display("FAIL ten_pulses got=%0d exp=1", pulse_total - start); end
    cmp_count++; if (last_out !== 8'd55) begin err_count++; $display("FAIL ten_value got=%0d exp=55", last_out); end
  endtask

  task automatic test_glitch_and_hold();
    io.k2 = 1'b0;
    tick(2);
    io.k2 = 1'b1;
    tick(20);
    cmp_count++; if (io.entry_value !== 7'd10) begin err_count++; $display("FAIL glitch_rejected got=%0d exp=10", io.entry_value); end
    io.k2 = 1'b0;
    tick(60);
    io.k2 = 1'b1;
    tick(20);
    cmp_count++; if (io.entry_value !== 7'd11) begin err_count++; $display("FAIL hold_one_step got=%0d exp=11", io.entry_value); end
  endtask

  task automatic test_mid_reset();
    int start;
    pulse_enter();
    tick(30);
    rst = 1'b0;
    tick(3);
    cmp_count++; if (dut.pc_r !== 5'd0) begin err_count++; $display("FAIL midrst_pc got=%0d exp=0", dut.pc_r); end
    cmp_count++; if (io.out_value !== 8'd0) begin err_count++; $display("FAIL midrst_out_value got=%0d exp=0", io.out_value); end
    cmp_count++; if (io.entry_value !== 7'd0) begin err_count++; $display("FAIL midrst_entry got=%0d exp=0", io.entry_value); end
    cmp_count++; if (io.halted !== 1'b0) begin err_count++; $display("FAIL midrst_halted got=%b exp=0", io.halted); end
    rst = 1'b1;
    start = pulse_total;
    tick(200);
    cmp_count++; if (pulse_total - start !== 0) begin err_count++; $display("FAIL midrst_no_output got=%0d exp=0", pulse_total - start); end
    cmp_count++; if (dut.pc_r !== 5'd0) begin err_count++; $display("FAIL midrst_stall_pc got=%0d exp=0", dut.pc_r); end
  endtask

  task automatic test_debounce_timing();
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    io2.enter = 1'b1;
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (io2.out_valid === 1'b1) got = 1'b1;
    end
    cmp_count++; if (got !== 1'b1) begin err_count++; $display("FAIL deb_output_seen got=%b exp=1 (within 400 cycles)", got); end
    cmp_count++; if (n < 200) begin err_count++; $display("FAIL deb_not_early got=%0d cycles exp>=200", n); end
    cmp_count++; if (n > 240) begin err_count++; $display("FAIL deb_not_late got=%0d cycles exp<=240", n); end
    cmp_count++; if (io2.out_value !== 8'd0) begin err_count++; $display("FAIL deb_value got=%0d exp=0", io2.out_value); end
    io2.enter = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_stall();
    test_sum4();
    test_sum99_wrap();
    test_zero_and_ten();
    test_glitch_and_hold();
    test_mid_reset();
    test_debounce_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
